// File: rtl/decode_pkg.sv
// Shared definitions for the decode/issue controller: opcodes, field positions,
// FSM states and the decoded-instruction record.
package decode_pkg;

    localparam logic [5:0] OP_LDI       = 6'h00;
    localparam logic [5:0] OP_MOV       = 6'h01;
    localparam logic [5:0] OP_LD        = 6'h02;
    localparam logic [5:0] OP_ST        = 6'h03;
    localparam logic [5:0] OP_ALU_FIRST = 6'h04;
    localparam logic [5:0] OP_ALU_LAST  = 6'h10;

    localparam int unsigned OP_MSB     = 31;
    localparam int unsigned OP_LSB     = 26;
    localparam int unsigned RDST2_MSB  = 25;
    localparam int unsigned RDST2_LSB  = 21;
    localparam int unsigned RDST1_MSB  = 20;
    localparam int unsigned RDST1_LSB  = 16;
    localparam int unsigned RSRCA_MSB  = 9;
    localparam int unsigned RSRCA_LSB  = 5;
    localparam int unsigned RSRCB_MSB  = 4;
    localparam int unsigned RSRCB_LSB  = 0;
    localparam int unsigned SRCADD_MSB = 7;
    localparam int unsigned SRCADD_LSB = 0;
    localparam int unsigned DSTADD_MSB = 25;
    localparam int unsigned DSTADD_LSB = 18;
    localparam int unsigned IMM_MSB    = 15;
    localparam int unsigned IMM_LSB    = 0;

    localparam int unsigned FIELD_RW = 5;

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StHold  = 2'd1,
        StErr   = 2'd2
    } state_e;

    // Decoded fields plus which register fields the class actually reads/writes.
    typedef struct packed {
        logic [5:0]          op;
        logic [FIELD_RW-1:0] rdst2;
        logic [FIELD_RW-1:0] rdst1;
        logic [FIELD_RW-1:0] rsrc2;
        logic [FIELD_RW-1:0] rsrc1;
        logic [7:0]          srcadd;
        logic [7:0]          dstadd;
        logic [15:0]         imm;
        logic                wr2;
        logic                wr1;
        logic                rd2;
        logic                rd1;
    } dec_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, two clear ports and a
// two-address set port; a set beats a clear to the same register.
module reg_scoreboard #(
    parameter int unsigned NREG = 32,
    parameter int unsigned RW   = 5
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_set_en_a,
    input  logic [RW-1:0]   i_set_addr_a,
    input  logic            i_set_en_b,
    input  logic [RW-1:0]   i_set_addr_b,
    input  logic            i_clr_en1,
    input  logic [RW-1:0]   i_clr_addr1,
    input  logic            i_clr_en2,
    input  logic [RW-1:0]   i_clr_addr2,
    output logic [NREG-1:0] o_busy
);

    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_busy_nxt;

    always_comb begin
        w_busy_nxt = r_busy;
        if (i_clr_en1) w_busy_nxt[i_clr_addr1] = 1'b0;
        if (i_clr_en2) w_busy_nxt[i_clr_addr2] = 1'b0;
        // Sets applied last so they take priority over same-edge writebacks.
        if (i_set_en_a) w_busy_nxt[i_set_addr_a] = 1'b1;
        if (i_set_en_b) w_busy_nxt[i_set_addr_b] = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign o_busy = r_busy;

endmodule

// File: rtl/decode_issue_ctrl.sv
// Captures one instruction from fetch, decodes it, holds it until the
// scoreboard shows its operands/destinations free, then issues it to execute.
module decode_issue_ctrl
    import decode_pkg::*;
#(
    parameter int unsigned NREG = 32,
    parameter int unsigned RW   = 5,
    parameter int unsigned SCW  = 16
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_instr_valid,
    input  logic [31:0]    i_instr,
    output logic           o_instr_ready,
    output logic           o_issue_valid,
    input  logic           i_issue_ready,
    output logic [5:0]     o_issue_op,
    output logic [RW-1:0]  o_issue_rdst2,
    output logic [RW-1:0]  o_issue_rdst1,
    output logic [RW-1:0]  o_issue_rsrc2,
    output logic [RW-1:0]  o_issue_rsrc1,
    output logic [7:0]     o_issue_srcadd,
    output logic [7:0]     o_issue_dstadd,
    output logic [15:0]    o_issue_imm,
    input  logic           i_wb_en2,
    input  logic [RW-1:0]  i_wb_addr2,
    input  logic           i_wb_en1,
    input  logic [RW-1:0]  i_wb_addr1,
    input  logic           i_flush,
    output logic           o_illegal,
    output logic [SCW-1:0] o_stall_cnt
);

    function automatic dec_t decode_fields(input logic [31:0] ins);
        dec_t       d;
        logic [5:0] op;
        d    = '0;
        op   = ins[OP_MSB:OP_LSB];
        d.op = op;
        if (op >= OP_ALU_FIRST) begin
            d.rdst2 = ins[RDST2_MSB:RDST2_LSB];
            d.rdst1 = ins[RDST1_MSB:RDST1_LSB];
            d.rsrc2 = ins[RSRCA_MSB:RSRCA_LSB];
            d.rsrc1 = ins[RSRCB_MSB:RSRCB_LSB];
            d.wr2   = 1'b1;
            d.wr1   = 1'b1;
            d.rd2   = 1'b1;
            d.rd1   = 1'b1;
        end else begin
            unique case (op)
                OP_LDI: begin
                    d.rdst2 = ins[RDST2_MSB:RDST2_LSB];
                    d.imm   = ins[IMM_MSB:IMM_LSB];
                    d.wr2   = 1'b1;
                end
                OP_MOV: begin
                    d.rdst2 = ins[RDST2_MSB:RDST2_LSB];
                    d.rsrc2 = ins[RSRCB_MSB:RSRCB_LSB];
                    d.wr2   = 1'b1;
                    d.rd2   = 1'b1;
                end
                OP_LD: begin
                    d.rdst2  = ins[RDST2_MSB:RDST2_LSB];
                    d.srcadd = ins[SRCADD_MSB:SRCADD_LSB];
                    d.wr2    = 1'b1;
                end
                OP_ST: begin
                    d.rsrc2  = ins[RSRCB_MSB:RSRCB_LSB];
                    d.dstadd = ins[DSTADD_MSB:DSTADD_LSB];
                    d.rd2    = 1'b1;
                end
                default: ;
            endcase
        end
        return d;
    endfunction

    state_e          r_state;
    state_e          w_state_nxt;
    dec_t            r_dec;
    logic            r_illegal;
    logic [SCW-1:0]  r_stall;
    logic [NREG-1:0] w_busy;
    logic            w_legal;
    logic            w_hazard;
    logic            w_issue_valid;
    logic            w_instr_ready;
    logic            w_handshake;
    logic            w_take;

    assign w_legal = (i_instr[OP_MSB:OP_LSB] <= OP_ALU_LAST);

    // RAW and WAW both show up as a busy bit on any register the class touches.
    assign w_hazard = (r_dec.wr2 & w_busy[r_dec.rdst2]) | (r_dec.wr1 & w_busy[r_dec.rdst1]) |
                      (r_dec.rd2 & w_busy[r_dec.rsrc2]) | (r_dec.rd1 & w_busy[r_dec.rsrc1]);

    always_comb begin
        w_state_nxt   = r_state;
        w_issue_valid = 1'b0;
        w_instr_ready = 1'b0;
        unique case (r_state)
            StEmpty: w_instr_ready = 1'b1;
            StHold: begin
                w_issue_valid = !w_hazard;
                w_instr_ready = !w_hazard & i_issue_ready;
            end
            StErr:   ;
            default: ;
        endcase
        w_handshake = w_issue_valid & i_issue_ready;
        w_take      = w_instr_ready & i_instr_valid & !i_flush;
        if (i_flush) begin
            w_state_nxt = StEmpty;
        end else if (w_take) begin
            w_state_nxt = w_legal ? StHold : StErr;
        end else if (w_handshake) begin
            w_state_nxt = StEmpty;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state   <= StEmpty;
            r_dec     <= '0;
            r_illegal <= 1'b0;
            r_stall   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_take && w_legal) begin
                r_dec <= decode_fields(i_instr);
            end
            if (w_take && !w_legal) begin
                r_illegal <= 1'b1;
            end else if (i_flush && r_state == StErr) begin
                r_illegal <= 1'b0;
            end
            if (r_state == StHold && w_hazard && r_stall != '1) begin
                r_stall <= r_stall + 1'b1;
            end
        end
    end

    reg_scoreboard #(
        .NREG (NREG),
        .RW   (RW)
    ) u_sb (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_set_en_a   (w_handshake & r_dec.wr2),
        .i_set_addr_a (r_dec.rdst2),
        .i_set_en_b   (w_handshake & r_dec.wr1),
        .i_set_addr_b (r_dec.rdst1),
        .i_clr_en1    (i_wb_en1),
        .i_clr_addr1  (i_wb_addr1),
        .i_clr_en2    (i_wb_en2),
        .i_clr_addr2  (i_wb_addr2),
        .o_busy       (w_busy)
    );

    assign o_instr_ready  = w_instr_ready;
    assign o_issue_valid  = w_issue_valid;
    assign o_issue_op     = r_dec.op;
    assign o_issue_rdst2  = r_dec.rdst2;
    assign o_issue_rdst1  = r_dec.rdst1;
    assign o_issue_rsrc2  = r_dec.rsrc2;
    assign o_issue_rsrc1  = r_dec.rsrc1;
    assign o_issue_srcadd = r_dec.srcadd;
    assign o_issue_dstadd = r_dec.dstadd;
    assign o_issue_imm    = r_dec.imm;
    assign o_illegal      = r_illegal;
    assign o_stall_cnt    = r_stall;

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Directed and randomized bench for decode_issue_ctrl against a behavioural
// model built from the opcode register-usage table.
module tb_decode_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        iv;
    logic [31:0] instr;
    logic        ir;
    logic        we2;
    logic [4:0]  wa2;
    logic        we1;
    logic [4:0]  wa1;
    logic        flush;

    logic        o_instr_ready;
    logic        o_issue_valid;
    logic [5:0]  o_issue_op;
    logic [4:0]  o_issue_rdst2;
    logic [4:0]  o_issue_rdst1;
    logic [4:0]  o_issue_rsrc2;
    logic [4:0]  o_issue_rsrc1;
    logic [7:0]  o_issue_srcadd;
    logic [7:0]  o_issue_dstadd;
    logic [15:0] o_issue_imm;
    logic        o_illegal;
    logic [15:0] o_stall_cnt;

    always #5 clk = ~clk;

    decode_issue_ctrl dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_instr_valid  (iv),
        .i_instr        (instr),
        .o_instr_ready  (o_instr_ready),
        .o_issue_valid  (o_issue_valid),
        .i_issue_ready  (ir),
        .o_issue_op     (o_issue_op),
        .o_issue_rdst2  (o_issue_rdst2),
        .o_issue_rdst1  (o_issue_rdst1),
        .o_issue_rsrc2  (o_issue_rsrc2),
        .o_issue_rsrc1  (o_issue_rsrc1),
        .o_issue_srcadd (o_issue_srcadd),
        .o_issue_dstadd (o_issue_dstadd),
        .o_issue_imm    (o_issue_imm),
        .i_wb_en2       (we2),
        .i_wb_addr2     (wa2),
        .i_wb_en1       (we1),
        .i_wb_addr1     (wa1),
        .i_flush        (flush),
        .o_illegal      (o_illegal),
        .o_stall_cnt    (o_stall_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    localparam int MEMPTY = 0;
    localparam int MHOLD  = 1;
    localparam int MERR   = 2;

    int          m_mode    = MEMPTY;
    logic [31:0] m_word    = '0;
    logic [31:0] m_pend    = '0;
    logic        m_illegal = 1'b0;
    int          m_stall   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_alu(input logic [5:0] op);
        return (op >= 6'h04) && (op <= 6'h10);
    endfunction

    function automatic logic [31:0] mk_ldi(input logic [4:0] rd, input logic [15:0] imm);
        return {6'h00, rd, 5'd0, imm};
    endfunction

    function automatic logic [31:0] mk_alu(input logic [5:0] op, input logic [4:0] d2,
                                           input logic [4:0] d1, input logic [4:0] s2,
                                           input logic [4:0] s1);
        return {op, d2, d1, 6'd0, s2, s1};
    endfunction

    function automatic logic [31:0] mk_st(input logic [4:0] s2, input logic [7:0] da);
        return {6'h03, da, 13'd0, s2};
    endfunction

    // Any register read or written by the instruction that is still pending.
    function automatic bit hazard_of(input logic [31:0] w);
        int         regs[$];
        logic [5:0] op;
        op = w[31:26];
        if (op <= 6'h02 || is_alu(op)) regs.push_back(int'(w[25:21]));
        if (is_alu(op)) begin
            regs.push_back(int'(w[20:16]));
            regs.push_back(int'(w[9:5]));
        end
        if (op == 6'h01 || op == 6'h03 || is_alu(op)) regs.push_back(int'(w[4:0]));
        foreach (regs[i]) if (m_pend[regs[i]]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drive(input logic v, input logic [31:0] w, input logic r, input logic f);
        iv    = v;
        instr = w;
        ir    = r;
        flush = f;
        we2   = 1'b0;
        wa2   = '0;
        we1   = 1'b0;
        wa1   = '0;
    endtask

    // Check outputs against the model, then advance model and DUT one clock.
    task automatic step();
        bit          hz, ev, er, hs, take, alu;
        logic [31:0] w, np, nword;
        logic [5:0]  op;
        int          nmode, nstall;
        logic        nill;
        #1;
        if (!rst_n) begin
            @(posedge clk);
            m_mode = MEMPTY; m_pend = '0; m_illegal = 1'b0; m_stall = 0;
            @(negedge clk);
            return;
        end
        w   = m_word;
        op  = w[31:26];
        alu = is_alu(op);
        hz  = (m_mode == MHOLD) && hazard_of(w);
        ev  = (m_mode == MHOLD) && !hz;
        er  = (m_mode == MEMPTY) || (ev && ir);
        check("instr_ready", 32'(o_instr_ready), 32'(er));
        check("issue_valid", 32'(o_issue_valid), 32'(ev));
        check("illegal", 32'(o_illegal), 32'(m_illegal));
        check("stall_cnt", 32'(o_stall_cnt), m_stall);
        check("scoreboard", dut.u_sb.o_busy, m_pend);
        if (ev) begin
            check("f_op", 32'(o_issue_op), 32'(op));
            check("f_rdst2", 32'(o_issue_rdst2), (op <= 6'h02 || alu) ? 32'(w[25:21]) : 0);
            check("f_rdst1", 32'(o_issue_rdst1), alu ? 32'(w[20:16]) : 0);
            check("f_rsrc2", 32'(o_issue_rsrc2), alu ? 32'(w[9:5]) :
                  (op == 6'h01 || op == 6'h03) ? 32'(w[4:0]) : 0);
            check("f_rsrc1", 32'(o_issue_rsrc1), alu ? 32'(w[4:0]) : 0);
            check("f_srcadd", 32'(o_issue_srcadd), (op == 6'h02) ? 32'(w[7:0]) : 0);
            check("f_dstadd", 32'(o_issue_dstadd), (op == 6'h03) ? 32'(w[25:18]) : 0);
            check("f_imm", 32'(o_issue_imm), (op == 6'h00) ? 32'(w[15:0]) : 0);
        end
        hs = ev && ir;
        np = m_pend;
        if (we2) np[wa2] = 1'b0;
        if (we1) np[wa1] = 1'b0;
        if (hs) begin
            if (op <= 6'h02 || alu) np[w[25:21]] = 1'b1;
            if (alu) np[w[20:16]] = 1'b1;
        end
        nmode  = m_mode;
        nword  = m_word;
        nill   = m_illegal;
        nstall = m_stall;
        if (hz && nstall < 65535) nstall++;
        take = iv && !flush && er;
        if (flush) begin
            nmode = MEMPTY;
            if (m_mode == MERR) nill = 1'b0;
        end else if (take) begin
            if (instr[31:26] <= 6'h10) begin
                nmode = MHOLD;
                nword = instr;
            end else begin
                nmode = MERR;
                nill  = 1'b1;
            end
        end else if (hs) begin
            nmode = MEMPTY;
        end
        @(posedge clk);
        m_pend = np; m_mode = nmode; m_word = nword; m_illegal = nill; m_stall = nstall;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] w;
        rst_n = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        step();
        step();
        rst_n = 1'b1;
        #1;
        check("rst_valid", 32'(o_issue_valid), 0);
        check("rst_ready", 32'(o_instr_ready), 1);
        check("rst_illegal", 32'(o_illegal), 0);
        check("rst_stall", 32'(o_stall_cnt), 0);
        check("rst_op", 32'(o_issue_op), 0);
        check("rst_rdst2", 32'(o_issue_rdst2), 0);
        check("rst_rdst1", 32'(o_issue_rdst1), 0);
        check("rst_rsrc2", 32'(o_issue_rsrc2), 0);
        check("rst_rsrc1", 32'(o_issue_rsrc1), 0);
        check("rst_srcadd", 32'(o_issue_srcadd), 0);
        check("rst_dstadd", 32'(o_issue_dstadd), 0);
        check("rst_imm", 32'(o_issue_imm), 0);

        // LDI r3,#0x1234
        drive(1'b1, mk_ldi(5'd3, 16'h1234), 1'b1, 1'b0);
        step();
        drive(1'b0, '0, 1'b1, 1'b0);
        #1;
        check("ldi_valid", 32'(o_issue_valid), 1);
        check("ldi_rdst2", 32'(o_issue_rdst2), 3);
        check("ldi_imm", 32'(o_issue_imm), 32'h1234);
        step();
        check("ldi_sb3", 32'(dut.u_sb.o_busy[3]), 1);

        // ALU r5,r6 <= r3,r4 stalls on r3 until its writeback
        drive(1'b1, mk_alu(6'h04, 5'd5, 5'd6, 5'd3, 5'd4), 1'b1, 1'b0);
        step();
        drive(1'b0, '0, 1'b1, 1'b0);
        repeat (4) step();
        #1;
        check("alu_stall4", 32'(o_stall_cnt), 4);
        check("alu_blocked", 32'(o_issue_valid), 0);
        we2 = 1'b1; wa2 = 5'd3;
        step();
        we2 = 1'b0;
        #1;
        check("alu_after_wb", 32'(o_issue_valid), 1);
        step();

        // WAW on r7; writeback of r7 coincident with the second issue
        drive(1'b0, '0, 1'b0, 1'b0);
        we2 = 1'b1; wa2 = 5'd5; we1 = 1'b1; wa1 = 5'd6;
        step();
        drive(1'b1, mk_ldi(5'd7, 16'h0007), 1'b1, 1'b0);
        step();
        drive(1'b1, mk_ldi(5'd7, 16'h0777), 1'b1, 1'b0);
        step();
        drive(1'b0, '0, 1'b1, 1'b0);
        #1;
        check("waw_hold", 32'(o_issue_valid), 0);
        step();
        we2 = 1'b1; wa2 = 5'd7;
        step();
        #1;
        check("waw_release", 32'(o_issue_valid), 1);
        step();
        we2 = 1'b0;
        check("waw_set_wins", 32'(dut.u_sb.o_busy[7]), 1);

        // ST r2 -> 0xA5
        drive(1'b1, mk_st(5'd2, 8'hA5), 1'b1, 1'b0);
        step();
        drive(1'b0, '0, 1'b1, 1'b0);
        #1;
        check("st_valid", 32'(o_issue_valid), 1);
        check("st_dstadd", 32'(o_issue_dstadd), 32'hA5);
        check("st_rsrc2", 32'(o_issue_rsrc2), 2);
        step();
        check("st_no_set", dut.u_sb.o_busy, 32'h0000_0080);

        // Illegal opcode sticks in ERR until flush
        w = {6'h2A, 26'h0123456};
        drive(1'b1, w, 1'b1, 1'b0);
        step();
        drive(1'b1, mk_ldi(5'd1, 16'h0001), 1'b1, 1'b0);
        #1;
        check("ill_flag", 32'(o_illegal), 1);
        check("ill_ready", 32'(o_instr_ready), 0);
        step();
        step();
        drive(1'b0, '0, 1'b0, 1'b1);
        step();
        drive(1'b1, mk_ldi(5'd8, 16'h0008), 1'b1, 1'b0);
        #1;
        check("flush_ill_clr", 32'(o_illegal), 0);
        check("flush_ready", 32'(o_instr_ready), 1);
        step();
        drive(1'b0, '0, 1'b1, 1'b0);
        step();

        // Held with issue_ready low, then flushed
        drive(1'b1, mk_ldi(5'd9, 16'hBEEF), 1'b0, 1'b0);
        step();
        drive(1'b0, '0, 1'b0, 1'b0);
        repeat (5) step();
        #1;
        check("hold_imm", 32'(o_issue_imm), 32'hBEEF);
        check("hold_rdst2", 32'(o_issue_rdst2), 9);
        drive(1'b0, '0, 1'b0, 1'b1);
        step();
        drive(1'b0, '0, 1'b0, 1'b0);
        #1;
        check("flush_valid", 32'(o_issue_valid), 0);
        check("flush_sb_kept", dut.u_sb.o_busy, 32'h0000_0180);
        step();

        // Randomized traffic over a small register window to force hazards
        for (int c = 0; c < 800; c++) begin
            w = $urandom;
            if ($urandom_range(0, 99) < 3) w[31:26] = 6'($urandom_range(17, 63));
            else                           w[31:26] = 6'($urandom_range(0, 16));
            w[25:21] = 5'($urandom_range(0, 7));
            w[20:16] = 5'($urandom_range(0, 7));
            w[9:5]   = 5'($urandom_range(0, 7));
            w[4:0]   = 5'($urandom_range(0, 7));
            drive(1'($urandom_range(0, 1)), w, ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 29) == 0));
            we2   = ($urandom_range(0, 2) == 0);
            wa2   = 5'($urandom_range(0, 7));
            we1   = ($urandom_range(0, 2) == 0);
            wa1   = 5'($urandom_range(0, 7));
            rst_n = ($urandom_range(0, 199) != 0);
            step();
        end
        rst_n = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
